// File: rtl/weight_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// weight_fetch_ctrl
// Read sequencer for the weight SRAM. A job fetches num_words consecutive
// words starting at base_addr. Reads are issued only when a FIFO slot is
// guaranteed for the returning word (1-cycle SRAM read latency). Words are
// presented to the PE array on a valid/ready stream with full backpressure.
//
// Ports:
//   clk, rst           clock / asynchronous active-high reset
//   start              job request, sampled only while idle
//   base_addr          first word address of the job
//   num_words          number of words to fetch (0 allowed)
//   busy               high from accepted start until done
//   done               1-cycle pulse, job complete (all words consumed)
//   err                1-cycle pulse, job rejected (address range violation)
//   sram_csb           SRAM chip enable, active-low
//   sram_wsb           SRAM write enable, active-low, tied high
//   sram_raddr         SRAM read address
//   sram_rdata         SRAM read data (valid the cycle after a request)
//   w_valid/w_ready    output stream handshake
//   w_data             output weight word (FIFO head)
// -----------------------------------------------------------------------------
module weight_fetch_ctrl #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 80,
   parameter int MEM_DEPTH  = 20250,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_words,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              sram_csb,
   output logic              sram_wsb,
   output logic [ADDR_W-1:0] sram_raddr,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              w_valid,
   output logic [DATA_W-1:0] w_data,
   input  logic              w_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] num_q;
   logic [ADDR_W-1:0] issued_q;
   logic [ADDR_W-1:0] raddr_q;
   logic              inflight_q;

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  fifo_cnt;

   logic [ADDR_W:0]   job_end;
   logic              range_bad;
   logic [CNT_W:0]    occupied;
   logic              issue;
   logic              last_issue;
   logic              push;
   logic              pop;

   // Range check uses one extra bit so base+num cannot wrap.
   assign job_end   = {1'b0, base_addr} + {1'b0, num_words};
   assign range_bad = job_end > (ADDR_W+1)'(MEM_DEPTH);

   // Credit: the in-flight word already owns a slot; same-cycle pops are
   // deliberately not credited so the FIFO can never overflow.
   assign occupied   = {1'b0, fifo_cnt} + (CNT_W+1)'(inflight_q);
   assign issue      = (state == FETCH) && (issued_q < num_q) &&
                       (occupied < (CNT_W+1)'(FIFO_DEPTH));
   assign last_issue = issue && ((issued_q + ADDR_W'(1)) == num_q);

   // Returning read data is always pushed the cycle after its request.
   assign push    = inflight_q;
   assign w_valid = (fifo_cnt != '0);
   assign pop     = w_valid && w_ready;
   assign w_data  = w_valid ? fifo_mem[rd_ptr] : '0;

   // Read port decoded straight from registered state; address holds when idle.
   assign sram_csb   = !issue;
   assign sram_wsb   = 1'b1;
   assign sram_raddr = issue ? (base_q + issued_q) : raddr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         base_q     <= '0;
         num_q      <= '0;
         issued_q   <= '0;
         raddr_q    <= '0;
         inflight_q <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
      end else begin
         done       <= 1'b0;
         err        <= 1'b0;
         inflight_q <= issue;

         if (issue) begin
            issued_q <= issued_q + ADDR_W'(1);
            raddr_q  <= sram_raddr;
         end

         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase

         case (state)
            IDLE: begin
               if (start) begin
                  if (range_bad) begin
                     err <= 1'b1;
                  end else if (num_words == '0) begin
                     done <= 1'b1;
                  end else begin
                     base_q   <= base_addr;
                     num_q    <= num_words;
                     issued_q <= '0;
                     busy     <= 1'b1;
                     state    <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (last_issue) state <= DRAIN;
            end
            DRAIN: begin
               // Nothing in flight and the last buffered word leaves now.
               if (!inflight_q && (fifo_cnt == CNT_W'(1)) && pop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO storage carries data only; occupancy gates its visibility.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= sram_rdata;
   end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
module tb_weight_fetch_ctrl;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 80;
   localparam int MEM_DEPTH = 20250;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] num_words;
   logic              busy, done, err;
   logic              sram_csb, sram_wsb;
   logic [ADDR_W-1:0] sram_raddr;
   logic [DATA_W-1:0] sram_rdata;
   logic              w_valid;
   logic [DATA_W-1:0] w_data;
   logic              w_ready;

   weight_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
      .busy(busy), .done(done), .err(err), .sram_csb(sram_csb), .sram_wsb(sram_wsb),
      .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .w_valid(w_valid),
      .w_data(w_data), .w_ready(w_ready)
   );

   always #5 clk = ~clk;

   // SRAM model: mem[i] = i, one-cycle read latency.
   always @(posedge clk) begin
      if (!sram_csb) sram_rdata <= {{(DATA_W-ADDR_W){1'b0}}, sram_raddr};
   end

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int done_cnt = 0;
   int outstanding = 0;
   int k_cyc = 0;
   logic [ADDR_W-1:0] last_raddr = '0;
   logic              prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;

   logic [ADDR_W-1:0] exp_addr [$];
   logic [DATA_W-1:0] exp_data [$];
   int read_cyc [$];
   int pop_cyc [$];

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         check("wsb_tied", DATA_W'(sram_wsb), DATA_W'(1));
         if (done) done_cnt++;
         if (prev_stall) begin
            check("stall_valid", DATA_W'(w_valid), DATA_W'(1));
            check("stall_data", w_data, prev_data);
         end
         if (!sram_csb) begin
            rd_cnt++;
            read_cyc.push_back(cyc);
            last_raddr = sram_raddr;
            check("read_while_busy", DATA_W'(busy), DATA_W'(1));
            if (exp_addr.size() == 0) check("unexpected_read", DATA_W'(sram_raddr), '1);
            else check("raddr", DATA_W'(sram_raddr), DATA_W'(exp_addr.pop_front()));
            outstanding++;
            if (outstanding > 4) check("fifo_credit", DATA_W'(outstanding), DATA_W'(4));
         end
         if (w_valid && w_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_data.size() == 0) check("unexpected_word", w_data, '1);
            else check("w_data", w_data, exp_data.pop_front());
            outstanding--;
         end
         prev_stall = w_valid && !w_ready;
         prev_data  = w_data;
      end
   end

   task automatic start_job(input int b, input int n);
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = ADDR_W'(b);
      num_words = ADDR_W'(n);
      if ((b + n <= MEM_DEPTH) && (n != 0)) begin
         for (int i = 0; i < n; i++) begin
            exp_addr.push_back(ADDR_W'(b + i));
            exp_data.push_back(DATA_W'(b + i));
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      k_cyc = cyc;
   endtask

   task automatic wait_done(input int max, input bit toggle);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < max; i++) begin
         @(posedge clk); #1;
         if (toggle) w_ready = !w_ready;
         if (done_cnt != d0) break;
      end
      repeat (3) @(posedge clk);
      #1;
      check("done_pulses", DATA_W'(done_cnt - d0), DATA_W'(1));
      check("busy_after_done", DATA_W'(busy), DATA_W'(0));
      check("addr_q_empty", DATA_W'(exp_addr.size()), DATA_W'(0));
      check("data_q_empty", DATA_W'(exp_data.size()), DATA_W'(0));
   endtask

   initial begin
      int r0;
      rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; w_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_csb", DATA_W'(sram_csb), DATA_W'(1));
      check("rst_busy", DATA_W'(busy), DATA_W'(0));
      check("rst_valid", DATA_W'(w_valid), DATA_W'(0));
      check("rst_wdata", w_data, '0);
      check("rst_raddr", DATA_W'(sram_raddr), '0);
      check("rst_done_err", DATA_W'({done, err}), '0);
      rst = 1'b0;

      // 1: basic job, timing
      read_cyc.delete(); pop_cyc.delete();
      start_job(21, 5);
      check("t1_busy", DATA_W'(busy), DATA_W'(1));
      wait_done(40, 1'b0);
      check("t1_nreads", DATA_W'(read_cyc.size()), DATA_W'(5));
      check("t1_npops", DATA_W'(pop_cyc.size()), DATA_W'(5));
      if (read_cyc.size() == 5 && pop_cyc.size() == 5) begin
         check("t1_first_read", DATA_W'(read_cyc[0]), DATA_W'(k_cyc));
         for (int i = 0; i < 5; i++) begin
            check("t1_read_cyc", DATA_W'(read_cyc[i]), DATA_W'(k_cyc + i));
            check("t1_pop_cyc", DATA_W'(pop_cyc[i]), DATA_W'(k_cyc + 2 + i));
         end
      end

      // 2: full backpressure
      w_ready = 1'b0;
      r0 = rd_cnt;
      start_job(0, 10);
      repeat (20) @(posedge clk);
      #1;
      check("t2_reads_stalled", DATA_W'(rd_cnt - r0), DATA_W'(4));
      check("t2_csb_held", DATA_W'(sram_csb), DATA_W'(1));
      check("t2_head", w_data, DATA_W'(0));
      w_ready = 1'b1;
      wait_done(60, 1'b0);

      // 3: toggling ready
      start_job(100, 16);
      wait_done(200, 1'b1);
      w_ready = 1'b1;

      // 4: zero length, range error, boundary
      r0 = rd_cnt;
      start_job(7, 0);
      check("t4_zero_done", DATA_W'(done), DATA_W'(1));
      check("t4_zero_busy", DATA_W'(busy), DATA_W'(0));
      @(posedge clk); #1;
      check("t4_zero_done_once", DATA_W'(done), DATA_W'(0));
      start_job(20248, 5);
      check("t4_err", DATA_W'(err), DATA_W'(1));
      check("t4_err_nodone", DATA_W'({done, busy}), '0);
      repeat (4) @(posedge clk);
      #1;
      check("t4_no_reads", DATA_W'(rd_cnt - r0), DATA_W'(0));
      check("t4_err_once", DATA_W'(err), DATA_W'(0));
      start_job(20245, 5);
      check("t4_edge_busy", DATA_W'(busy), DATA_W'(1));
      wait_done(40, 1'b0);
      check("t4_last_raddr", DATA_W'(last_raddr), DATA_W'(20249));

      // 5: start while busy is ignored
      start_job(300, 8);
      @(posedge clk); #1;
      start = 1'b1; base_addr = ADDR_W'(600); num_words = ADDR_W'(3);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(60, 1'b0);

      // 6: asynchronous reset mid-fetch
      w_ready = 1'b0;
      start_job(0, 10);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t6_csb", DATA_W'(sram_csb), DATA_W'(1));
      check("t6_valid", DATA_W'(w_valid), DATA_W'(0));
      check("t6_busy", DATA_W'(busy), DATA_W'(0));
      exp_addr.delete(); exp_data.delete();
      outstanding = 0;
      @(posedge clk); #3;
      rst = 1'b0;
      w_ready = 1'b1;
      start_job(50, 2);
      wait_done(40, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no completion expected completion");
      $fatal(1, "timeout");
   end

endmodule
